fac_ctrl: RTL and testbench

FAC_CTRL -- requirements
Module: fac_ctrl

---
 rtl/fac_pkg.sv | 12 +
 rtl/fac_ctrl_if.sv | 11 +
 rtl/fac_ctrl_ns.sv | 54 +++++
 rtl/fac_ctrl.sv | 48 ++++
 tb/tb_fac_ctrl.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/fac_pkg.sv
// fac_pkg: state encoding and datapath widths shared by the factorial controller
package fac_pkg;
  localparam int OPW  = 64;
  localparam int ACCW = 128;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    REQ   = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/fac_ctrl_if.sv
// fac_ctrl_if: request/response link between the controller and an external multiplier
interface fac_ctrl_if;
  import fac_pkg::*;
  logic            mul_start;
  logic [OPW-1:0]  mul_a;
  logic [OPW-1:0]  mul_b;
  logic            mul_done;
  logic [ACCW-1:0] mul_result;
  modport master (output mul_start, mul_a, mul_b, input mul_done, mul_result);
  modport slave  (input mul_start, mul_a, mul_b, output mul_done, mul_result);
endinterface

// File: rtl/fac_ctrl_ns.sv
// fac_ctrl_ns: next-state and next-datapath function of the factorial controller
module fac_ctrl_ns
  import fac_pkg::*;
(
  input  state_t          state,
  input  logic [OPW-1:0]  k,
  input  logic [ACCW-1:0] acc,
  input  logic            overflow,
  input  logic            op_start,
  input  logic            op_clear,
  input  logic [OPW-1:0]  operand,
  input  logic            mul_done,
  input  logic [ACCW-1:0] mul_result,
  output state_t          state_n,
  output logic [OPW-1:0]  k_n,
  output logic [ACCW-1:0] acc_n,
  output logic            ovf_n
);
  always_comb begin
    state_n = state;
    k_n     = k;
    acc_n   = acc;
    ovf_n   = overflow;
    case (state)
      IDLE: if (op_start) begin
        state_n = CHECK;
        k_n     = operand;
        acc_n   = ACCW'(1);
        ovf_n   = 1'b0;
      end
      CHECK: if (k <= OPW'(1)) state_n = DONE;
      else if (|acc[ACCW-1:OPW]) begin
        ovf_n   = 1'b1;
        state_n = DONE;
      end
      else state_n = REQ;
      REQ: state_n = WAIT;
      WAIT: if (mul_done) begin
        acc_n   = mul_result;
        k_n     = k - OPW'(1);
        state_n = CHECK;
      end
      DONE: state_n = DONE;
      default: state_n = IDLE;
    endcase
    // clear overrides start and any multiplier completion in the same cycle
    if (op_clear) begin
      state_n = IDLE;
      k_n     = '0;
      acc_n   = '0;
      ovf_n   = 1'b0;
    end
  end
endmodule

// File: rtl/fac_ctrl.sv
// fac_ctrl: computes N! by iterated requests to an external multiplier
module fac_ctrl
  import fac_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            op_start,
  input  logic            op_clear,
  input  logic [OPW-1:0]  operand,
  fac_ctrl_if.master      mul,
  output logic [ACCW-1:0] result,
  output logic            done,
  output logic            busy,
  output logic            overflow,
  output logic [2:0]      state
);
  state_t          cur, nxt;
  logic [OPW-1:0]  k, k_n;
  logic [ACCW-1:0] acc, acc_n;
  logic            ovf_n;
  fac_ctrl_ns u_ns (
    .state(cur), .k(k), .acc(acc), .overflow(overflow),
    .op_start(op_start), .op_clear(op_clear), .operand(operand),
    .mul_done(mul.mul_done), .mul_result(mul.mul_result),
    .state_n(nxt), .k_n(k_n), .acc_n(acc_n), .ovf_n(ovf_n)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur      <= IDLE;
      k        <= '0;
      acc      <= '0;
      overflow <= 1'b0;
    end else begin
      cur      <= nxt;
      k        <= k_n;
      acc      <= acc_n;
      overflow <= ovf_n;
    end
  end
  // acc and k do not change in REQ/WAIT, so operands stay stable until mul_done
  assign mul.mul_start = cur == REQ;
  assign mul.mul_a     = acc[OPW-1:0];
  assign mul.mul_b     = k;
  assign result        = acc;
  assign done          = cur == DONE;
  assign busy          = cur == CHECK || cur == REQ || cur == WAIT;
  assign state         = cur;
endmodule

// File: tb/tb_fac_ctrl.sv
// tb_fac_ctrl: randomized scoreboard bench for fac_ctrl with a latency-programmable multiplier
module tb_fac_ctrl;
  logic         clk = 0;
  logic         reset_n = 0;
  logic         op_start = 0;
  logic         op_clear = 0;
  logic [63:0]  operand = '0;
  logic [127:0] result;
  logic         done, busy, overflow;
  logic [2:0]   state;
  int           total = 0;
  int           bad = 0;
  int           nstart = 0;
  int           lat = 2;
  bit           hold = 0;
  bit           done_q = 0;
  logic [127:0] mq[$];
  logic [128:0] rq[$];

  fac_ctrl_if mul();
  fac_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
    .operand(operand), .mul(mul), .result(result), .done(done), .busy(busy),
    .overflow(overflow), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  initial begin
    logic [63:0] pa, pb;
    mul.mul_done = 0;
    mul.mul_result = '0;
    forever begin
      @(posedge clk); #1;
      if (mul.mul_start) begin
        pa = mul.mul_a;
        pb = mul.mul_b;
        repeat (lat - 1) begin @(posedge clk); #1; end
        while (hold) begin @(posedge clk); #1; end
        mul.mul_result = {64'd0, pa} * {64'd0, pb};
        mul.mul_done = 1;
        @(posedge clk); #1;
        mul.mul_done = 0;
        mul.mul_result = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  always @(negedge clk) begin
    logic [127:0] e;
    logic [128:0] r;
    if (mul.mul_start) begin
      nstart++;
      if (mq.size() == 0) chk("mul_unexpected", 1, 0);
      else begin
        e = mq.pop_front();
        chk("mul_a", {64'd0, mul.mul_a}, {64'd0, e[127:64]});
        chk("mul_b", {64'd0, mul.mul_b}, {64'd0, e[63:0]});
      end
    end
    if (done && !done_q) begin
      if (rq.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        r = rq.pop_front();
        chk("result", result, r[127:0]);
        chk("overflow", {127'd0, overflow}, {127'd0, r[128]});
      end
    end
    done_q = done;
  end

  task automatic run(input logic [63:0] n, input int l, input bit noise);
    logic [127:0] acc;
    logic [63:0]  k;
    bit           ovf;
    int           cnt, n0, cyc;
    acc = 1; k = n; ovf = 0; cnt = 0;
    while (k > 1) begin
      if (acc[127:64] != 0) begin ovf = 1; break; end
      mq.push_back({acc[63:0], k});
      acc = {64'd0, acc[63:0]} * {64'd0, k};
      k--;
      cnt++;
    end
    rq.push_back({ovf, acc});
    lat = l;
    n0 = nstart;
    @(negedge clk); operand = n; op_start = 1;
    @(negedge clk); op_start = 0;
    chk("lat_check", {125'd0, state}, 1);
    for (cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 0 && n <= 1) chk("lat_done", {127'd0, done}, 1);
      if (noise && busy) op_start = 1'($urandom_range(0, 1));
    end
    chk("timeout", {127'd0, done}, 1);
    chk("n_mul", nstart - n0, cnt);
    chk("ovf_flag", {127'd0, overflow}, {127'd0, ovf});
    @(negedge clk); op_start = 0; op_clear = 1;
    @(negedge clk); op_clear = 0;
    chk("clr_state", {125'd0, state}, 0);
    chk("clr_result", result, 0);
  endtask

  task automatic abort_wait(input bit use_reset);
    hold = 1;
    lat = 2;
    mq.push_back({64'd1, 64'd5});
    @(negedge clk); operand = 64'd5; op_start = 1;
    @(negedge clk); op_start = 0;
    for (int i = 0; i < 50 && state != 3'd3; i++) @(negedge clk);
    chk("reach_wait", {125'd0, state}, 3);
    if (use_reset) reset_n = 0; else op_clear = 1;
    @(negedge clk); reset_n = 1; op_clear = 0;
    chk("abort_state", {125'd0, state}, 0);
    chk("abort_result", result, 0);
    chk("abort_flags", {124'd0, done, busy, overflow, mul.mul_start}, 0);
    hold = 0;
    repeat (6) @(negedge clk);
    chk("late_state", {125'd0, state}, 0);
    chk("late_result", result, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_state", {125'd0, state}, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {124'd0, done, busy, overflow, mul.mul_start}, 0);
    reset_n = 1;
    run(64'd5, 2, 0);
    run(64'd0, 2, 0);
    run(64'd1, 3, 0);
    run(64'd20, 3, 0);
    run(64'd25, 2, 0);
    run(64'd6, 4, 1);
    @(negedge clk); operand = 64'd7; op_start = 1; op_clear = 1;
    @(negedge clk); op_start = 0; op_clear = 0;
    chk("start_clear_state", {125'd0, state}, 0);
    chk("start_clear_busy", {127'd0, busy}, 0);
    abort_wait(0);
    abort_wait(1);
    run(64'd3, 2, 0);
    repeat (8) run(64'($urandom_range(0, 24)), $urandom_range(2, 4), 1'($urandom_range(0, 1)));
    repeat (4) @(negedge clk);
    chk("mq_left", mq.size(), 0);
    chk("rq_left", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
